rob_commit_unit: RTL and testbench

//  Reader/retire end of the ROB. Examines the head entry each cycle and retires it in program order

---
 rtl/rob_commit_unit_pkg.sv | 38 +++
 rtl/rob_commit_unit_freeq.sv | 61 ++++++
 rtl/rob_commit_unit.sv | 119 +++++++++++
 tb/tb_rob_commit_unit.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/rob_commit_unit_pkg.sv
// Shared ROB line layout, commit FSM encodings and field helpers for the retire end of the ROB.
package rob_commit_unit_pkg;

    localparam int ROB_PREG_W = 6;
    localparam int ROB_PC_W   = 32;
    localparam int ROB_IDX_W  = 6;
    localparam int ROB_SIZE   = 1 << ROB_IDX_W;

    // Line layout, MSB first: {valid, rd, rd_old, pc, comp}
    localparam int ROB_WIDTH     = 2 + 2 * ROB_PREG_W + ROB_PC_W;
    localparam int ROB_COMP      = 0;
    localparam int ROB_PC_LO     = 1;
    localparam int ROB_PC_HI     = ROB_PC_LO + ROB_PC_W - 1;
    localparam int ROB_RD_OLD_LO = ROB_PC_HI + 1;
    localparam int ROB_RD_OLD_HI = ROB_RD_OLD_LO + ROB_PREG_W - 1;
    localparam int ROB_RD_LO     = ROB_RD_OLD_HI + 1;
    localparam int ROB_RD_HI     = ROB_RD_LO + ROB_PREG_W - 1;
    localparam int ROB_VALID     = ROB_RD_HI + 1;

    typedef enum logic [1:0] {
        COMMIT_RUN   = 2'd0,
        COMMIT_STALL = 2'd1,
        COMMIT_FLUSH = 2'd2
    } commit_state_e;

    typedef struct packed {
        logic                  valid;
        logic [ROB_PREG_W-1:0] rd;
        logic [ROB_PREG_W-1:0] rd_old;
        logic [ROB_PC_W-1:0]   pc;
        logic                  comp;
    } rob_entry_t;

    function automatic logic entry_retirable(input rob_entry_t e);
        return e.valid & e.comp;
    endfunction

endpackage

// File: rtl/rob_commit_unit_freeq.sv
// Small FIFO holding old physical registers waiting to be handed back to the free list.
module freereg_release_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] pop_data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign pop_data_o = mem_q[rd_ptr_q];
    assign pop_ok     = pop_i & ~empty_o;
    // A push into a full buffer is only legal when a pop frees the slot in the same cycle.
    assign push_ok    = push_i & (~full_o | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/rob_commit_unit.sv
// Retire end of the ROB: pops complete head entries in order, queues rd_old for release, reports commits.
module rob_commit_unit
    import rob_commit_unit_pkg::*;
#(
    parameter int FREEQ_DEPTH = 4,
    parameter int PREG_W      = ROB_PREG_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ROB_WIDTH-1:0] head_entry,
    input  logic [ROB_IDX_W-1:0] head_ptr,
    input  logic                 flush,
    output logic                 retire,
    output logic                 free_valid,
    output logic [PREG_W-1:0]    free_preg,
    input  logic                 free_ready,
    output logic                 commit_valid,
    output logic [31:0]          commit_pc,
    output logic [PREG_W-1:0]    commit_rd,
    output logic [ROB_IDX_W-1:0] commit_idx,
    output logic [31:0]          retired_cnt
);

    rob_entry_t    head;
    commit_state_e state_q, state_d;
    logic          retirable;
    logic          buf_full;
    logic          buf_empty;
    logic          buf_pop;
    logic          buf_push;

    logic                 commit_valid_q, commit_valid_d;
    logic [31:0]          commit_pc_q, commit_pc_d;
    logic [PREG_W-1:0]    commit_rd_q, commit_rd_d;
    logic [ROB_IDX_W-1:0] commit_idx_q, commit_idx_d;
    logic [31:0]          retired_cnt_q, retired_cnt_d;

    assign head      = rob_entry_t'(head_entry);
    assign retirable = entry_retirable(head);
    assign buf_pop   = ~buf_empty & free_ready;
    // Physical register 0 is hardwired and never returns to the free list.
    assign buf_push  = retire & (head.rd_old != '0);

    freereg_release_fifo #(
        .DEPTH (FREEQ_DEPTH),
        .W     (PREG_W)
    ) u_freeq (
        .clk         (clk),
        .rst         (rst),
        .push_i      (buf_push),
        .push_data_i (head.rd_old),
        .pop_i       (buf_pop),
        .pop_data_o  (free_preg),
        .full_o      (buf_full),
        .empty_o     (buf_empty)
    );

    assign free_valid = ~buf_empty;

    always_ff @(posedge clk) begin
        if (rst) state_q <= COMMIT_RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = COMMIT_FLUSH;
        end else begin
            case (state_q)
                COMMIT_RUN:   if (buf_full && retirable) state_d = COMMIT_STALL;
                COMMIT_STALL: if (buf_pop) state_d = COMMIT_RUN;
                COMMIT_FLUSH: state_d = COMMIT_RUN;
                default:      state_d = COMMIT_RUN;
            endcase
        end
    end

    always_comb begin
        retire = ~rst && (state_q == COMMIT_RUN) && retirable && ~flush && ~buf_full;
    end

    always_comb begin
        commit_valid_d = retire;
        commit_pc_d    = commit_pc_q;
        commit_rd_d    = commit_rd_q;
        commit_idx_d   = commit_idx_q;
        retired_cnt_d  = retired_cnt_q;
        if (retire) begin
            commit_pc_d   = head.pc;
            commit_rd_d   = head.rd;
            commit_idx_d  = head_ptr;
            retired_cnt_d = retired_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            commit_valid_q <= 1'b0;
            commit_pc_q    <= '0;
            commit_rd_q    <= '0;
            commit_idx_q   <= '0;
            retired_cnt_q  <= '0;
        end else begin
            commit_valid_q <= commit_valid_d;
            commit_pc_q    <= commit_pc_d;
            commit_rd_q    <= commit_rd_d;
            commit_idx_q   <= commit_idx_d;
            retired_cnt_q  <= retired_cnt_d;
        end
    end

    assign commit_valid = commit_valid_q;
    assign commit_pc    = commit_pc_q;
    assign commit_rd    = commit_rd_q;
    assign commit_idx   = commit_idx_q;
    assign retired_cnt  = retired_cnt_q;

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed and randomized bench for rob_commit_unit against a queue-based reference model.
module tb_rob_commit_unit;
    import rob_commit_unit_pkg::*;

    localparam int DEPTH = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [ROB_WIDTH-1:0] head_entry;
    logic [5:0]           head_ptr;
    logic                 flush;
    logic                 retire;
    logic                 free_valid;
    logic [5:0]           free_preg;
    logic                 free_ready;
    logic                 commit_valid;
    logic [31:0]          commit_pc;
    logic [5:0]           commit_rd;
    logic [5:0]           commit_idx;
    logic [31:0]          retired_cnt;

    rob_commit_unit #(.FREEQ_DEPTH(DEPTH), .PREG_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .head_entry   (head_entry),
        .head_ptr     (head_ptr),
        .flush        (flush),
        .retire       (retire),
        .free_valid   (free_valid),
        .free_preg    (free_preg),
        .free_ready   (free_ready),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_rd    (commit_rd),
        .commit_idx   (commit_idx),
        .retired_cnt  (retired_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errs    = 0;

    // Reference model: mode 0 = running, 1 = stalled on full buffer, 2 = one-cycle flush recovery
    int         m_mode;
    int         m_q[$];
    bit         m_cv;
    logic [31:0] m_pc;
    logic [5:0]  m_rd;
    logic [5:0]  m_idx;
    logic [31:0] m_cnt;
    logic [5:0]  hp = 6'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit r, input bit v, input bit c, input logic [5:0] rd,
                         input logic [5:0] rdo, input logic [31:0] pc, input bit fl, input bit rdy);
        bit exp_ret, full, pop, retirable;
        @(negedge clk);
        rst        = r;
        head_entry = {v, rd, rdo, pc, c};
        head_ptr   = hp;
        flush      = fl;
        free_ready = rdy;
        #1;
        full      = (m_q.size() == DEPTH);
        retirable = v & c;
        exp_ret   = !r && (m_mode == 0) && retirable && !fl && !full;
        check("retire", {31'd0, retire}, {31'd0, exp_ret});
        if (!r) begin
            check("free_valid", {31'd0, free_valid}, {31'd0, m_q.size() > 0});
            if (m_q.size() > 0) check("free_preg", {26'd0, free_preg}, m_q[0]);
        end
        pop = !r && (m_q.size() > 0) && rdy;
        @(posedge clk);
        #1;
        if (r) begin
            m_mode = 0; m_q.delete(); m_cv = 0;
            m_pc = 0; m_rd = 0; m_idx = 0; m_cnt = 0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (exp_ret && rdo != 0) m_q.push_back(int'(rdo));
            m_cv = exp_ret;
            if (exp_ret) begin
                m_pc = pc; m_rd = rd; m_idx = hp; m_cnt = m_cnt + 1;
            end
            if (fl)               m_mode = 2;
            else if (m_mode == 0) m_mode = (full && retirable) ? 1 : 0;
            else if (m_mode == 1) m_mode = pop ? 0 : 1;
            else                  m_mode = 0;
        end
        if (exp_ret) hp = hp + 6'd1;
        check("commit_valid", {31'd0, commit_valid}, {31'd0, m_cv});
        check("commit_pc", commit_pc, m_pc);
        check("commit_rd", {26'd0, commit_rd}, {26'd0, m_rd});
        check("commit_idx", {26'd0, commit_idx}, {26'd0, m_idx});
        check("retired_cnt", retired_cnt, m_cnt);
    endtask

    initial begin
        logic [31:0] cnt0;
        rst = 1'b1; head_entry = '0; head_ptr = '0; flush = 1'b0; free_ready = 1'b0;
        m_mode = 0; m_cv = 0; m_pc = 0; m_rd = 0; m_idx = 0; m_cnt = 0;

        // Reset with a complete head present
        cycle(1, 1, 1, 6'd5, 6'd3, 32'h40, 0, 1);
        cycle(1, 1, 1, 6'd5, 6'd3, 32'h40, 0, 1);
        check("rst_cnt", retired_cnt, 32'd0);
        check("rst_free_valid", {31'd0, free_valid}, 32'd0);

        // Single commit
        cycle(0, 1, 1, 6'd5, 6'd3, 32'h40, 0, 1);
        check("single_pc", commit_pc, 32'h40);
        check("single_cnt", retired_cnt, 32'd1);
        cycle(0, 0, 0, 6'd0, 6'd0, 32'h0, 0, 1);
        cycle(0, 0, 0, 6'd0, 6'd0, 32'h0, 0, 1);

        // Incomplete head, then completes once
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 6'd7, 6'd9, 32'h80, 0, 1);
        cycle(0, 1, 1, 6'd7, 6'd9, 32'h80, 0, 1);
        cycle(0, 0, 0, 6'd0, 6'd0, 32'h0, 0, 1);
        cycle(0, 0, 0, 6'd0, 6'd0, 32'h0, 0, 1);

        // Backpressure fills the release buffer, then drains in order
        for (int i = 1; i <= 4; i++) cycle(0, 1, 1, 6'(10 + i), 6'(i), 32'(32'h100 + 4 * i), 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 6'd20, 6'd30, 32'h200, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 1, 1, 6'd20, 6'd0, 32'h200, 0, 1);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 6'd0, 6'd0, 32'h0, 0, 1);

        // rd_old of zero is never released
        cnt0 = m_cnt;
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 6'(40 + i), 6'd0, 32'(32'h300 + 4 * i), 0, 1);
        check("p0_cnt", retired_cnt, cnt0 + 32'd3);
        check("p0_free_valid", {31'd0, free_valid}, 32'd0);

        // Flush keeps already-buffered registers
        cycle(0, 1, 1, 6'd50, 6'd21, 32'h400, 0, 0);
        cycle(0, 1, 1, 6'd51, 6'd22, 32'h404, 0, 0);
        cycle(0, 1, 1, 6'd52, 6'd23, 32'h408, 1, 0);
        cycle(0, 1, 1, 6'd52, 6'd23, 32'h408, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 6'd0, 6'd0, 32'h0, 0, 1);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [5:0] rdo;
            rdo = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            cycle(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) != 0),
                  6'($urandom), rdo, $urandom,
                  ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 2) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
